mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared word-addressed memory port between two requesters: instruction fetch (IF) and data memory (DM, load/store).
- Sits between the core's fetch/LSU stages and the memory model. Drives the memory's address, write strobe and write data, and samples its asynchronous read data.
- Wait states are configurable so the bench can model slower memory.
- When both ports request together, the grant alternates between them (round-robin).

Parameters:
- ADDR_WID, 30, word address width (byte address bits 31:2)
- WAIT_CYC, 1, extra memory wait cycles per access; legal range 0..7

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_WID  fetch word address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  fetch data
- dm_req  in  1  data request; held with its fields until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  store byte enables
- dm_addr  in  ADDR_WID  data word address
- dm_wdata  in  32  store data
- dm_ready  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data or store acknowledge, 1-cycle pulse
- dm_rdata  out  32  load data; 0 for a store acknowledge
- mem_addr  out  ADDR_WID  memory word address
- mem_we  out  1  memory write strobe
- mem_be  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (asynchronous, combinational from mem_addr)

Behaviour:
- Clock and reset: one clock, clk. nrst is asynchronous, active-low.
- Reset values:
  - FSM = IDLE, wait counter = 0, last_grant = IF.
  - All ready/rvalid outputs = 0; rdata outputs = 0.
  - mem_addr = 0, mem_we = 0, mem_be = 0, mem_wdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - if_ready/dm_ready are combinational and asserted only here, at most one at a time.
  - Only DM requests: DM wins. Only IF requests: IF wins.
  - Both request: the port not in last_grant wins.
  - On a grant: latch the port id, address, we, be and wdata (IF is always a read with be = 0); update last_grant; clear the counter; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Lasts WAIT_CYC+1 cycles.
  - mem_addr is driven from the latched address for the whole state.
  - Counter increments each cycle; the final cycle is counter == WAIT_CYC.
  - Final cycle only:
    - mem_we = latched we; mem_be and mem_wdata valid.
    - Register mem_rdata into the granted port's rdata (0 if a store).
    - Go to RESP.
- RESP:
  - Granted port's rvalid = 1 for exactly one cycle; the other port's rvalid stays 0.
  - No grant is issued in RESP. Go to IDLE.
- Outside ACCESS: mem_we = 0, mem_be = 0; mem_addr and mem_wdata hold their last values.
- Timing:
  - Grant in cycle T gives rvalid in cycle T+WAIT_CYC+2.
  - Minimum spacing between grants is WAIT_CYC+3 cycles.
- rdata holds its value until the same port's next response.
- Requester contract: a request dropped before its ready is allowed and is simply not served. Inputs changing after ready have no effect on the transaction in flight.
- Reset asserted mid-ACCESS: the transaction is aborted, no mem_we pulse and no rvalid, and all state returns to reset values immediately.
- WAIT_CYC = 0: ACCESS lasts one cycle.

Test Plan:
- Single fetch, WAIT_CYC=1: if_req with if_addr=0x10 and memory word[0x10]=0xDEADBEEF -> if_ready at T; mem_addr=0x10 during T+1..T+2; if_rvalid=1 and if_rdata=0xDEADBEEF at T+3 only.
- Store then load: dm_we=1, dm_be=4'b0011, dm_addr=5, dm_wdata=0x12345678 over a word holding 0xAAAAAAAA -> exactly one mem_we pulse; dm_rvalid with dm_rdata=0. Then a load from address 5 -> dm_rdata=0xAAAA5678.
- Contention: if_req and dm_req held high continuously from reset -> grant order DM, IF, DM, IF; grants spaced exactly WAIT_CYC+3 cycles; no cycle has both readys high.
- WAIT_CYC=0 and WAIT_CYC=7 builds: a single load -> rvalid at T+2 and T+9 respectively.
- Reset mid-access: store granted, nrst pulled low in the second ACCESS cycle -> mem_we never asserts; all outputs read 0 immediately; memory word is unchanged.
- Withdrawn request: dm_req pulsed for one cycle while a fetch is in ACCESS -> no DM grant, no dm_rvalid, arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory port between instruction
// fetch (IF) and data memory (DM). One transaction in flight at a time:
// IDLE grants, ACCESS spends WAIT_CYC+1 cycles on the memory, RESP pulses
// the granted port's rvalid. Simultaneous requests alternate (round-robin).
//
// Ports:
//   clk, nrst                      clock (rising edge), async active-low reset
//   if_req/if_addr                 fetch request (held until if_ready)
//   if_ready/if_rvalid/if_rdata    fetch accept, response pulse, read data
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  load/store request (held until dm_ready)
//   dm_ready/dm_rvalid/dm_rdata    data accept, response pulse, load data (0 on store)
//   mem_addr/mem_we/mem_be/mem_wdata     memory command
//   mem_rdata                      memory read data (combinational from mem_addr)
module mem_arbiter #(
  parameter int ADDR_WID = 30,
  parameter int WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                if_req,
  input  logic [ADDR_WID-1:0] if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [31:0]         if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [3:0]          dm_be,
  input  logic [ADDR_WID-1:0] dm_addr,
  input  logic [31:0]         dm_wdata,
  output logic                dm_ready,
  output logic                dm_rvalid,
  output logic [31:0]         dm_rdata,
  output logic [ADDR_WID-1:0] mem_addr,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYC);

  logic [1:0]          state;
  logic [2:0]          cnt;
  logic                last_dm;   // 1 = DM got the previous grant
  logic                gnt_dm;    // port owning the transaction in flight
  logic [ADDR_WID-1:0] addr_q;
  logic                we_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                pick_dm, pick_if, final_cyc;

  // DM wins when alone or when IF had the last grant. Gating with nrst keeps
  // the readys low while reset is held even if requests are already up.
  always_comb begin
    pick_dm   = nrst && (state == IDLE) && dm_req && (!if_req || !last_dm);
    pick_if   = nrst && (state == IDLE) && if_req && !pick_dm;
    final_cyc = (state == ACCESS) && (cnt == LAST_CNT);
  end

  assign if_ready  = pick_if;
  assign dm_ready  = pick_dm;
  assign if_rvalid = (state == RESP) && !gnt_dm;
  assign dm_rvalid = (state == RESP) && gnt_dm;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = final_cyc && we_q;
  assign mem_be    = final_cyc ? be_q : 4'b0000;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      last_dm  <= 1'b0;
      gnt_dm   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'd0;
      if_rdata <= 32'd0;
      dm_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_dm || pick_if) begin
            gnt_dm  <= pick_dm;
            last_dm <= pick_dm;
            addr_q  <= pick_dm ? dm_addr : if_addr;
            we_q    <= pick_dm && dm_we;
            be_q    <= pick_dm ? dm_be : 4'b0000;
            // fetches leave the last write data on the bus
            if (pick_dm) wdata_q <= dm_wdata;
            cnt     <= 3'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (final_cyc) begin
            if (gnt_dm) dm_rdata <= we_q ? 32'd0 : mem_rdata;
            else        if_rdata <= mem_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 30;
  localparam int W  = 1;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [3:0]    dm_be, mem_be;
  logic [31:0]   dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_ready, if_rvalid, dm_ready, dm_rvalid, mem_we;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];

  mem_arbiter #(.ADDR_WID(AW), .WAIT_CYC(W)) u_dut (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // Side builds with WAIT_CYC = 0 and 7; their memory returns addr ^ CAFE0000.
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic [1:0]    s_if_ready, s_if_rvalid, s_dm_ready, s_dm_rvalid, s_mem_we;
  logic [31:0]   s_if_rdata [2];
  logic [31:0]   s_dm_rdata [2];
  logic [31:0]   s_mem_wdata [2];
  logic [31:0]   s_mem_rdata [2];
  logic [AW-1:0] s_mem_addr [2];
  logic [3:0]    s_mem_be [2];
  for (genvar g = 0; g < 2; g++) begin : g_side
    assign s_mem_rdata[g] = {2'b00, s_mem_addr[g]} ^ 32'hCAFE0000;
    mem_arbiter #(.ADDR_WID(AW), .WAIT_CYC(g == 0 ? 0 : 7)) u_side (
      .clk(clk), .nrst(nrst),
      .if_req(1'b0), .if_addr('0), .if_ready(s_if_ready[g]),
      .if_rvalid(s_if_rvalid[g]), .if_rdata(s_if_rdata[g]),
      .dm_req(s_req), .dm_we(1'b0), .dm_be(4'b0000), .dm_addr(s_addr),
      .dm_wdata(32'd0), .dm_ready(s_dm_ready[g]), .dm_rvalid(s_dm_rvalid[g]),
      .dm_rdata(s_dm_rdata[g]), .mem_addr(s_mem_addr[g]), .mem_we(s_mem_we[g]),
      .mem_be(s_mem_be[g]), .mem_wdata(s_mem_wdata[g]), .mem_rdata(s_mem_rdata[g]));
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transaction-level reference model ----------------
  // A grant seen in cycle c occupies the memory for c+1..c+W+1, answers in
  // c+W+2 and frees the arbiter from c+W+3 on.
  int          free_at = 0, fin_at = -1, resp_at = -1, g_cyc = -10;
  bit          m_last_dm = 0, g_if = 0, g_dm = 0;
  bit          t_dm = 0, t_we = 0;
  logic [3:0]  t_be = 0;
  logic [AW-1:0] t_addr = 0;
  logic [31:0] t_wdata = 0, e_if_rd = 0, e_dm_rd = 0;

  always @(negedge clk) begin
    logic e_ifr, e_dmr, in_acc;
    if (!nrst) begin
      chk("rst_if_ready",  32'(if_ready), 0);
      chk("rst_dm_ready",  32'(dm_ready), 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
      chk("rst_if_rdata",  if_rdata, 0);
      chk("rst_dm_rdata",  dm_rdata, 0);
      chk("rst_mem_addr",  32'(mem_addr), 0);
      chk("rst_mem_we",    32'(mem_we), 0);
      chk("rst_mem_be",    32'(mem_be), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      free_at = cyc; fin_at = -1; resp_at = -1; g_cyc = -10;
      m_last_dm = 0; e_if_rd = 0; e_dm_rd = 0; g_if = 0; g_dm = 0;
    end else begin
      e_ifr = 0; e_dmr = 0;
      if (cyc >= free_at) begin
        if (dm_req && (!if_req || !m_last_dm)) e_dmr = 1;
        else if (if_req) e_ifr = 1;
      end
      in_acc = (cyc > g_cyc) && (cyc <= fin_at);
      chk("if_ready",  32'(if_ready),  32'(e_ifr));
      chk("dm_ready",  32'(dm_ready),  32'(e_dmr));
      chk("if_rvalid", 32'(if_rvalid), 32'(cyc == resp_at && !t_dm));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(cyc == resp_at && t_dm));
      chk("if_rdata",  if_rdata, e_if_rd);
      chk("dm_rdata",  dm_rdata, e_dm_rd);
      chk("mem_we",    32'(mem_we), 32'(cyc == fin_at && t_we));
      if (in_acc) chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      if (cyc == fin_at) chk("mem_be", 32'(mem_be), 32'(t_be));
      else if (!in_acc) chk("mem_be_idle", 32'(mem_be), 0);
      if (cyc == fin_at && t_we) chk("mem_wdata", mem_wdata, t_wdata);
      if (cyc == fin_at) begin
        if (t_we) begin
          for (int b = 0; b < 4; b++)
            if (t_be[b]) ref_mem[t_addr[5:0]][8*b +: 8] = t_wdata[8*b +: 8];
          e_dm_rd = 0;
        end else if (t_dm) e_dm_rd = ref_mem[t_addr[5:0]];
        else e_if_rd = ref_mem[t_addr[5:0]];
      end
      if (e_ifr || e_dmr) begin
        t_dm = e_dmr; m_last_dm = e_dmr;
        t_addr = e_dmr ? dm_addr : if_addr;
        t_we = e_dmr && dm_we;
        t_be = e_dmr ? dm_be : 4'b0000;
        t_wdata = dm_wdata;
        g_cyc = cyc; fin_at = cyc + W + 1; resp_at = cyc + W + 2; free_at = cyc + W + 3;
      end
      g_if = e_ifr; g_dm = e_dmr;
    end
  end

  // ---------------- stimulus and directed literal checks ----------------
  initial begin
    int k, nwe, rv, ng, both;
    int gc[8];
    int gp[8];
    int srv[2];
    logic [31:0] rd, keep;
    logic [31:0] srd[2];

    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA5A50000 + 32'(i);
    end
    mem[16] = 32'hDEADBEEF;
    mem[5]  = 32'hAAAAAAAA;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    s_req = 0; s_addr = 0;
    repeat (3) @(posedge clk);
    #1 nrst = 1;

    // single fetch
    if_req = 1; if_addr = 30'h10;
    @(negedge clk); chk("fetch_ready_T", 32'(if_ready), 1);
    @(posedge clk); #1 if_req = 0; if_addr = 30'h3;
    @(negedge clk); chk("fetch_addr_T1", 32'(mem_addr), 32'h10); chk("fetch_nv_T1", 32'(if_rvalid), 0);
    @(negedge clk); chk("fetch_addr_T2", 32'(mem_addr), 32'h10); chk("fetch_nv_T2", 32'(if_rvalid), 0);
    @(negedge clk); chk("fetch_rvalid_T3", 32'(if_rvalid), 1); chk("fetch_rdata_T3", if_rdata, 32'hDEADBEEF);
    @(negedge clk); chk("fetch_nv_T4", 32'(if_rvalid), 0); chk("fetch_hold_T4", if_rdata, 32'hDEADBEEF);

    // store then load
    @(posedge clk); #1 dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 5; dm_wdata = 32'h12345678;
    @(negedge clk); chk("store_ready", 32'(dm_ready), 1);
    @(posedge clk); #1 dm_req = 0; dm_wdata = 32'hFFFFFFFF;
    nwe = 0; rv = 0; rd = 32'hX;
    for (k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (dm_rvalid) begin rv = k; rd = dm_rdata; end
    end
    chk("store_we_pulses", 32'(nwe), 1);
    chk("store_ack_lat", 32'(rv), 3);
    chk("store_ack_rdata", rd, 0);
    chk("store_mem_word", mem[5], 32'hAAAA5678);
    @(posedge clk); #1 dm_req = 1; dm_we = 0; dm_addr = 5;
    @(negedge clk); chk("load_ready", 32'(dm_ready), 1);
    @(posedge clk); #1 dm_req = 0;
    rv = 0;
    for (k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (dm_rvalid) begin rv = k; rd = dm_rdata; end
    end
    chk("load_lat", 32'(rv), 3);
    chk("load_rdata", rd, 32'hAAAA5678);

    // contention from reset
    @(posedge clk); #1 nrst = 0;
    if_req = 1; if_addr = 1; dm_req = 1; dm_we = 0; dm_addr = 2;
    @(posedge clk); #1 nrst = 1;
    ng = 0; both = 0;
    for (k = 0; k < 14; k++) begin
      @(negedge clk);
      if (if_ready && dm_ready) both++;
      if ((if_ready || dm_ready) && ng < 8) begin gc[ng] = cyc; gp[ng] = dm_ready ? 1 : 0; ng++; end
    end
    chk("cont_grants", 32'(ng), 4);
    chk("cont_both", 32'(both), 0);
    for (int i = 0; i < 4 && i < ng; i++) chk("cont_port", 32'(gp[i]), (i % 2 == 0) ? 1 : 0);
    for (int i = 0; i < 3 && i + 1 < ng; i++) chk("cont_space", 32'(gc[i+1] - gc[i]), W + 3);
    @(posedge clk); #1 if_req = 0; dm_req = 0;
    repeat (6) @(posedge clk);

    // reset during the second ACCESS cycle of a store
    #1 keep = mem[7];
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 7; dm_wdata = 32'h0BADF00D;
    @(negedge clk); chk("abort_ready", 32'(dm_ready), 1);
    @(posedge clk); #1 dm_req = 0;
    @(posedge clk); #1 nrst = 0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_dm_rvalid", 32'(dm_rvalid), 0);
    chk("abort_mem_addr", 32'(mem_addr), 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1;
    chk("abort_mem_word", mem[7], keep);

    // DM request withdrawn while a fetch is in ACCESS
    if_req = 1; if_addr = 3;
    @(negedge clk); chk("wd_fetch_ready", 32'(if_ready), 1);
    @(posedge clk); #1 if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 9;
    @(posedge clk); #1 dm_req = 0;
    nwe = 0; rv = 0;
    for (k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dm_ready || dm_rvalid) nwe++;
      if (if_rvalid) rv++;
    end
    chk("wd_no_dm", 32'(nwe), 0);
    chk("wd_if_resp", 32'(rv), 1);
    @(posedge clk); #1 dm_req = 1;
    @(negedge clk); chk("wd_idle_again", 32'(dm_ready), 1);
    @(posedge clk); #1 dm_req = 0;
    repeat (6) @(posedge clk);

    // WAIT_CYC = 0 and 7 builds
    #1 s_req = 1; s_addr = 9;
    @(negedge clk); chk("side_ready", 32'(s_dm_ready), 32'(2'b11));
    @(posedge clk); #1 s_req = 0;
    srv[0] = 0; srv[1] = 0; srd[0] = 0; srd[1] = 0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if (s_dm_rvalid[g] && srv[g] == 0) begin srv[g] = k; srd[g] = s_dm_rdata[g]; end
    end
    chk("w0_lat", 32'(srv[0]), 2);
    chk("w7_lat", 32'(srv[1]), 9);
    chk("w0_rdata", srd[0], 32'hCAFE0009);
    chk("w7_rdata", srd[1], 32'hCAFE0009);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1500) nrst = 0;
      if (i == 1503) nrst = 1;
      if (if_req && !g_if) begin
        if ($urandom_range(0, 19) == 0) if_req = 0;
      end else begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = AW'($urandom_range(0, 31));
      end
      if (dm_req && !g_dm) begin
        if ($urandom_range(0, 19) == 0) dm_req = 0;
      end else begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_we = 1'($urandom_range(0, 1));
        dm_be = 4'($urandom_range(0, 15));
        dm_addr = AW'($urandom_range(0, 31));
        dm_wdata = $urandom;
      end
    end
    @(posedge clk); #1 if_req = 0; dm_req = 0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
